// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared load tag type and default scoreboard depth
package core_pkg;

    localparam int LOAD_SB_DEPTH = 4;

    typedef struct packed {
        logic       fw;
        logic [4:0] rd;
    } sb_tag_t;

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - in-order FIFO of outstanding load tags
module tag_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = LOAD_SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  sb_tag_t                  push_tag,
    input  logic                     pop,
    output sb_tag_t                  head_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    sb_tag_t       r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full     = (r_count == CNT_MAX);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign head_tag = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - load-use stall scoreboard with in-order response tracking
// LOAD_SB_FLOAT_EN adds 32 float entries to the 32 integer ones.
module load_scoreboard
    import core_pkg::*;
#(
    parameter int DEPTH = LOAD_SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memr_id,
    input  logic [4:0]               rd_id,
    input  logic                     fw_id,
    input  logic [4:0]               rs1_id,
    input  logic [4:0]               rs2_id,
    input  logic [1:0]               float_read,
    input  logic                     inst,
    input  logic                     resp_valid,
    output logic                     ld_stall,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     resp_err
);

`ifdef LOAD_SB_FLOAT_EN
    localparam int SB_W = 6;
`else
    localparam int SB_W = 5;
`endif
    localparam int SB_N = 1 << SB_W;

    function automatic logic [SB_W-1:0] sb_idx(input sb_tag_t t);
`ifdef LOAD_SB_FLOAT_EN
        return {t.fw, t.rd};
`else
        return t.rd;
`endif
    endfunction

    // x0 is never tracked; without float support float tags are never tracked.
    function automatic logic sb_tracked(input sb_tag_t t);
`ifdef LOAD_SB_FLOAT_EN
        return t.fw || (t.rd != 5'd0);
`else
        return !t.fw && (t.rd != 5'd0);
`endif
    endfunction

    logic [SB_N-1:0] r_sb;
    logic            r_resp_err;
    sb_tag_t         w_new_tag;
    sb_tag_t         w_rs1_tag;
    sb_tag_t         w_rs2_tag;
    sb_tag_t         w_head_tag;
    logic            w_full;
    logic            w_empty;
    logic            w_raw;
    logic            w_waw;
    logic            w_issue;
    logic            w_pop;

    assign w_new_tag = {fw_id, rd_id};
    assign w_rs1_tag = {float_read[1], rs1_id};
    assign w_rs2_tag = {float_read[0], rs2_id};

    assign w_raw = (sb_tracked(w_rs1_tag) && r_sb[sb_idx(w_rs1_tag)]) ||
                   (sb_tracked(w_rs2_tag) && r_sb[sb_idx(w_rs2_tag)]);
    assign w_waw = memr_id && sb_tracked(w_new_tag) && r_sb[sb_idx(w_new_tag)];

    // Registered state only, so a same-cycle response never releases the stall early.
    assign ld_stall = inst && (w_raw || w_waw || (memr_id && w_full));
    assign w_issue  = inst && memr_id && !ld_stall;
    assign w_pop    = resp_valid && !w_empty;
    assign full     = w_full;
    assign resp_err = r_resp_err;

    tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_issue),
        .push_tag (w_new_tag),
        .pop      (w_pop),
        .head_tag (w_head_tag),
        .full     (w_full),
        .empty    (w_empty),
        .count    (pending)
    );

    // The set follows the clear so a same-cycle issue wins on a shared register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb       <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_pop && sb_tracked(w_head_tag))
                r_sb[sb_idx(w_head_tag)] <= 1'b0;
            if (w_issue && sb_tracked(w_new_tag))
                r_sb[sb_idx(w_new_tag)] <= 1'b1;
            if (resp_valid && w_empty)
                r_resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// tb/tb_load_scoreboard.sv - directed table plus randomized model check of load_scoreboard
module tb_load_scoreboard;
    import core_pkg::*;

    localparam int DEPTH = LOAD_SB_DEPTH;
    localparam int PW    = $clog2(DEPTH) + 1;
`ifdef LOAD_SB_FLOAT_EN
    localparam logic FLT = 1'b1;
`else
    localparam logic FLT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          memr_id = 1'b0;
    logic [4:0]    rd_id = '0;
    logic          fw_id = 1'b0;
    logic [4:0]    rs1_id = '0;
    logic [4:0]    rs2_id = '0;
    logic [1:0]    float_read = '0;
    logic          inst = 1'b0;
    logic          resp_valid = 1'b0;
    logic          ld_stall;
    logic          full;
    logic [PW-1:0] pending;
    logic          resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .memr_id    (memr_id),
        .rd_id      (rd_id),
        .fw_id      (fw_id),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .float_read (float_read),
        .inst       (inst),
        .resp_valid (resp_valid),
        .ld_stall   (ld_stall),
        .full       (full),
        .pending    (pending),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic       inst;
        logic       memr;
        logic       fw;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] fr;
        logic       resp;
        logic       stall;
        int         pend;
        logic       full;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    // Reference model: outstanding loads in issue order, plus sticky error.
    sb_tag_t mq[$];
    logic    m_err = 1'b0;

    function automatic vec_t mk(logic i, logic m, logic f, int rd, int r1, int r2,
                                logic [1:0] fr, logic rsp, logic st, int pd, logic fl, logic er);
        vec_t v;
        v.inst = i; v.memr = m; v.fw = f;
        v.rd = 5'(rd); v.rs1 = 5'(r1); v.rs2 = 5'(r2);
        v.fr = fr; v.resp = rsp;
        v.stall = st; v.pend = pd; v.full = fl; v.err = er;
        return v;
    endfunction

    function automatic logic m_busy(logic f, logic [4:0] r);
        if (!f && r == 5'd0) return 1'b0;
        if (f && !FLT) return 1'b0;
        foreach (mq[k]) if (mq[k].fw == f && mq[k].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_stall();
        return inst && (m_busy(float_read[1], rs1_id) || m_busy(float_read[0], rs2_id) ||
                        (memr_id && (m_busy(fw_id, rd_id) || mq.size() == DEPTH)));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tbl, input string nm);
        logic ms;
        sb_tag_t t;
        inst = v.inst; memr_id = v.memr; fw_id = v.fw; rd_id = v.rd;
        rs1_id = v.rs1; rs2_id = v.rs2; float_read = v.fr; resp_valid = v.resp;
        @(negedge clk);
        ms = m_stall();
        if (use_tbl) begin
            chk({nm, ".stall"},   32'(ld_stall), 32'(v.stall));
            chk({nm, ".pending"}, 32'(pending),  32'(v.pend));
            chk({nm, ".full"},    32'(full),     32'(v.full));
            chk({nm, ".err"},     32'(resp_err), 32'(v.err));
        end else begin
            chk({nm, ".stall"},   32'(ld_stall), 32'(ms));
            chk({nm, ".pending"}, 32'(pending),  32'(mq.size()));
            chk({nm, ".full"},    32'(full),     32'(mq.size() == DEPTH));
            chk({nm, ".err"},     32'(resp_err), 32'(m_err));
        end
        @(posedge clk);
        if (resp_valid) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_err = 1'b1;
        end
        if (inst && memr_id && !ms) begin
            t.fw = fw_id; t.rd = rd_id;
            mq.push_back(t);
        end
        #1;
    endtask

    initial begin
        vec_t v;
        // inst memr fw rd rs1 rs2 fr resp | stall pend full err
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,5,0,0,2'b00,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,5,0,2'b00,0, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0,5,0,2'b00,1, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0,5,0,2'b00,0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,1,0,0,2'b00,0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,2,0,0,2'b00,0, 0,1,0,0));
        tbl.push_back(mk(1,1,0,3,0,0,2'b00,0, 0,2,0,0));
        tbl.push_back(mk(1,1,0,4,0,0,2'b00,0, 0,3,0,0));
        tbl.push_back(mk(1,1,0,6,0,0,2'b00,0, 1,4,1,0));
        tbl.push_back(mk(1,1,0,6,0,0,2'b00,1, 1,4,1,0));
        tbl.push_back(mk(1,1,0,6,0,0,2'b00,0, 0,3,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,4,1,0));
        tbl.push_back(mk(1,1,0,7,0,0,2'b00,1, 0,3,0,0));
        tbl.push_back(mk(1,0,0,0,3,7,2'b00,0, 1,3,0,0));
        tbl.push_back(mk(1,0,0,0,3,0,2'b00,0, 0,3,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,3,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,2,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,1,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,2'b00,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,2'b00,0, 0,1,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,2'b00,0, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,2,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,0, 0,0,0,1));
        tbl.push_back(mk(1,1,0,9,0,0,2'b00,0, 0,0,0,1));
        tbl.push_back(mk(1,1,0,9,0,0,2'b00,0, 1,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,0, 0,0,0,1));
        tbl.push_back(mk(1,1,1,3,0,0,2'b00,0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0,3,0,2'b00,0, 0,1,0,1));
        tbl.push_back(mk(1,0,0,0,3,0,2'b10,0, FLT,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,3,2'b01,0, FLT,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,1, 0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,2'b00,0, 0,0,0,1));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.stall",   32'(ld_stall), 32'd0);
        chk("reset.pending", 32'(pending),  32'd0);
        chk("reset.full",    32'(full),     32'd0);
        chk("reset.err",     32'(resp_err), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // Load in flight across an asynchronous reset is forgotten.
        run_cycle(mk(1,1,0,5,0,0,2'b00,0, 0,0,0,1), 1'b1, "rst_seq0");
        inst = 1'b1; memr_id = 1'b0; rs1_id = 5'd5; rs2_id = 5'd0; float_read = 2'b00;
        resp_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst.stall",   32'(ld_stall), 32'd0);
        chk("async_rst.pending", 32'(pending),  32'd0);
        chk("async_rst.full",    32'(full),     32'd0);
        chk("async_rst.err",     32'(resp_err), 32'd0);
        mq.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        run_cycle(mk(1,0,0,0,5,0,2'b00,1, 0,0,0,0), 1'b1, "rst_seq1");
        run_cycle(mk(0,0,0,0,0,0,2'b00,0, 0,0,0,1), 1'b1, "rst_seq2");

        rst = 1'b1;
        #2 rst = 1'b0;
        mq.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 3000; n++) begin
            v.inst = ($urandom_range(0, 9) < 8);
            v.memr = $urandom_range(0, 1);
            v.fw   = ($urandom_range(0, 3) == 0);
            v.rd   = 5'($urandom_range(0, 7));
            v.rs1  = 5'($urandom_range(0, 7));
            v.rs2  = 5'($urandom_range(0, 7));
            v.fr   = 2'($urandom_range(0, 3));
            v.resp = ($urandom_range(0, 9) < 3);
            v.stall = 1'b0; v.pend = 0; v.full = 1'b0; v.err = 1'b0;
            run_cycle(v, 1'b0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
